ghost_mode_scheduler: RTL and testbench

Central controller that sequences ghost behaviour for all ghost movers.
- Runs the global scatter/chase timeline and the frightened (power-pellet) window.
- Tracks the per-ghost life-cycle HOUSE -> ACTIVE -> FRIGHT -> EATEN -> ACTIVE.
- Issues release and direction-reverse pulses that the ghost motion blocks consume each frame.
- Sits between the pellet/collision logic and the ghost motion blocks; it is advanced once per frame_clk.

---
 rtl/ghost_pkg.sv | 44 ++++
 rtl/ghost_life_fsm.sv | 71 +++++++
 rtl/ghost_mode_scheduler.sv | 174 +++++++++++++++++
 tb/tb_ghost_mode_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// -----------------------------------------------------------------------------
// ghost_pkg
// Shared types and constants for the ghost mode scheduler and its per-ghost
// life-cycle FSMs: ghost state encoding, timeline state encoding, default
// frame counts and the house-release pellet table.
// -----------------------------------------------------------------------------
package ghost_pkg;

  // Encoding is visible on the ghost_state output bus, so values are fixed.
  typedef enum logic [1:0] {
    GS_HOUSE  = 2'd0,
    GS_ACTIVE = 2'd1,
    GS_FRIGHT = 2'd2,
    GS_EATEN  = 2'd3
  } ghost_state_t;

  // SCAT(k)/CHASE(k) share one enum value each; k lives in a phase counter.
  typedef enum logic [1:0] {
    TL_SCATTER     = 2'd0,
    TL_CHASE       = 2'd1,
    TL_CHASE_FINAL = 2'd2
  } timeline_state_t;

  localparam int TIMER_W = 16;  // wide enough for every frame-count parameter
  localparam int DOT_W   = 8;   // saturating pellet counter

  localparam int DEF_SCATTER_FRAMES = 420;
  localparam int DEF_CHASE_FRAMES   = 1200;
  localparam int DEF_NUM_SCATTER    = 3;
  localparam int DEF_FRIGHT_FRAMES  = 360;
  localparam int DEF_FLASH_FRAMES   = 120;
  localparam int DEF_IDLE_FRAMES    = 240;

  // Pellets eaten before ghost i may leave the house.
  localparam int RELEASE_N = 4;
  localparam logic [DOT_W-1:0] RELEASE_DOTS [RELEASE_N] = '{8'd0, 8'd0, 8'd30, 8'd60};

  // Ghosts beyond the table only leave via the idle timer (or a full counter).
  function automatic logic [DOT_W-1:0] release_dots(input int idx);
    if (idx < RELEASE_N) return RELEASE_DOTS[idx[1:0]];
    return '1;
  endfunction

endpackage

// File: rtl/ghost_life_fsm.sv
// -----------------------------------------------------------------------------
// ghost_life_fsm
// Life cycle of one ghost: HOUSE -> ACTIVE -> FRIGHT -> EATEN -> ACTIVE.
// Ports:
//   frame_clk, Reset  clock and synchronous active-high reset
//   game_en           low = hold state, no release pulse
//   caught            Pac-Man collided with this ghost this frame
//   home              level, ghost has reached the house entrance
//   fright_start      power pellet eaten this frame
//   fright_end        frightened window expires on this edge
//   release_req       scheduler selected this ghost to leave the house
//   state             registered life-cycle state
//   release_pulse     registered one-frame pulse on HOUSE -> ACTIVE
//   catch_hit         combinational: a catch that counts toward score_mult
// -----------------------------------------------------------------------------
module ghost_life_fsm
  import ghost_pkg::*;
#(
  parameter bit START_ACTIVE = 1'b0
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         game_en,
  input  logic         caught,
  input  logic         home,
  input  logic         fright_start,
  input  logic         fright_end,
  input  logic         release_req,
  output ghost_state_t state,
  output logic         release_pulse,
  output logic         catch_hit
);

  // Only a FRIGHT ghost can be eaten; evaluated on the pre-edge state.
  assign catch_hit = caught && (state == GS_FRIGHT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and update order inside the block is irrelevant.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= START_ACTIVE ? GS_ACTIVE : GS_HOUSE;
      release_pulse <= 1'b0;
    end else if (!game_en) begin
      release_pulse <= 1'b0;
    end else begin
      release_pulse <= 1'b0;
      case (state)
        GS_HOUSE: begin
          if (release_req) begin
            state         <= GS_ACTIVE;
            release_pulse <= 1'b1;
          end
        end
        GS_ACTIVE: begin
          if (fright_start) state <= GS_FRIGHT;
        end
        GS_FRIGHT: begin
          // A catch beats a simultaneous power pellet; a reload beats expiry.
          if (caught)                          state <= GS_EATEN;
          else if (!fright_start && fright_end) state <= GS_ACTIVE;
        end
        GS_EATEN: begin
          // Returning eyes always come back ACTIVE, even mid-window.
          if (home) state <= GS_ACTIVE;
        end
        default: state <= GS_HOUSE;
      endcase
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// -----------------------------------------------------------------------------
// ghost_mode_scheduler
// Central ghost behaviour controller, advanced once per frame_clk. Runs the
// scatter/chase timeline, the frightened window, house release (pellet count
// and idle timer) and the catch score multiplier; per-ghost state lives in
// one ghost_life_fsm per ghost.
// Ports:
//   frame_clk, Reset  clock and synchronous active-high reset
//   game_en           low = freeze: everything holds, pulses are 0
//   pellet_eaten      one-frame pulse, normal pellet
//   power_eaten       one-frame pulse, power pellet
//   ghost_caught      per-ghost collision pulse
//   ghost_home        per-ghost level, eaten ghost reached house entrance
//   global_mode       0 = SCATTER, 1 = CHASE
//   ghost_state       2 bits per ghost: 0 HOUSE, 1 ACTIVE, 2 FRIGHT, 3 EATEN
//   release_pulse     per-ghost one-frame pulse when leaving HOUSE
//   reverse           one-frame pulse: ACTIVE/FRIGHT ghosts reverse
//   flash             frightened window is in its final FLASH_FRAMES
//   score_mult        catch index in current window (200/400/800/1600)
// -----------------------------------------------------------------------------
module ghost_mode_scheduler
  import ghost_pkg::*;
#(
  parameter int NUM_GHOSTS     = 4,
  parameter int SCATTER_FRAMES = DEF_SCATTER_FRAMES,
  parameter int CHASE_FRAMES   = DEF_CHASE_FRAMES,
  parameter int NUM_SCATTER    = DEF_NUM_SCATTER,
  parameter int FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
  parameter int FLASH_FRAMES   = DEF_FLASH_FRAMES,
  parameter int IDLE_FRAMES    = DEF_IDLE_FRAMES
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    game_en,
  input  logic                    pellet_eaten,
  input  logic                    power_eaten,
  input  logic [NUM_GHOSTS-1:0]   ghost_caught,
  input  logic [NUM_GHOSTS-1:0]   ghost_home,
  output logic                    global_mode,
  output logic [2*NUM_GHOSTS-1:0] ghost_state,
  output logic [NUM_GHOSTS-1:0]   release_pulse,
  output logic                    reverse,
  output logic                    flash,
  output logic [1:0]              score_mult
);

  localparam int PHASE_W = (NUM_SCATTER > 1) ? $clog2(NUM_SCATTER) : 1;

  timeline_state_t      tl_state_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [TIMER_W-1:0]   tl_timer_q;
  logic [TIMER_W-1:0]   fright_q;
  logic [TIMER_W-1:0]   idle_q;
  logic [DOT_W-1:0]     dot_q;

  ghost_state_t         g_state [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] g_hit;
  logic [NUM_GHOSTS-1:0] rel_req;

  logic                 pellet_any;
  logic                 force_rel;
  logic                 fright_end;
  logic                 tl_run;
  logic                 tl_expire;
  logic [DOT_W:0]       dot_sum;
  logic [DOT_W-1:0]     dot_next;
  logic [TIMER_W-1:0]   fright_next;
  logic [1:0]           score_next;
  logic                 found;

  assign pellet_any = pellet_eaten || power_eaten;
  assign force_rel  = !pellet_any && (idle_q == TIMER_W'(IDLE_FRAMES - 1));
  assign fright_end = (fright_q == TIMER_W'(1)) && !power_eaten;
  // The timeline is frozen for the whole frightened window.
  assign tl_run     = (fright_q == '0) && (tl_state_q != TL_CHASE_FINAL);
  assign tl_expire  = tl_run && (tl_timer_q == TIMER_W'(1));

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dot_sum  = {1'b0, dot_q} + {{DOT_W{1'b0}}, pellet_eaten} + {{DOT_W{1'b0}}, power_eaten};
    dot_next = dot_sum[DOT_W] ? '1 : dot_sum[DOT_W-1:0];

    // Single release per frame: lowest-index eligible HOUSE ghost. The idle
    // timeout makes every HOUSE ghost eligible.
    rel_req = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (!found && (g_state[i] == GS_HOUSE) && (force_rel || (dot_next >= release_dots(i)))) begin
        rel_req[i] = 1'b1;
        found      = 1'b1;
      end
    end

    if (power_eaten)         fright_next = TIMER_W'(FRIGHT_FRAMES);
    else if (fright_q != '0) fright_next = fright_q - TIMER_W'(1);
    else                     fright_next = fright_q;

    // Catches count against the pre-edge state; a power pellet in the same
    // frame restarts the count from zero before adding them.
    score_next = power_eaten ? 2'd0 : score_mult;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (g_hit[i] && (score_next != 2'd3)) score_next = score_next + 2'd1;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      tl_state_q  <= TL_SCATTER;
      phase_q     <= '0;
      tl_timer_q  <= TIMER_W'(SCATTER_FRAMES);
      global_mode <= 1'b0;
      fright_q    <= '0;
      idle_q      <= '0;
      dot_q       <= '0;
      reverse     <= 1'b0;
      flash       <= 1'b0;
      score_mult  <= 2'd0;
    end else if (!game_en) begin
      reverse <= 1'b0;
    end else begin
      reverse    <= power_eaten || tl_expire;
      fright_q   <= fright_next;
      flash      <= (fright_next != '0) && (fright_next <= TIMER_W'(FLASH_FRAMES));
      score_mult <= score_next;
      dot_q      <= dot_next;
      idle_q     <= (pellet_any || force_rel) ? '0 : idle_q + TIMER_W'(1);

      if (tl_expire) begin
        case (tl_state_q)
          TL_SCATTER: begin
            tl_state_q  <= TL_CHASE;
            tl_timer_q  <= TIMER_W'(CHASE_FRAMES);
            global_mode <= 1'b1;
          end
          TL_CHASE: begin
            if (phase_q == PHASE_W'(NUM_SCATTER - 1)) begin
              tl_state_q <= TL_CHASE_FINAL;
              tl_timer_q <= '0;
            end else begin
              tl_state_q  <= TL_SCATTER;
              phase_q     <= phase_q + PHASE_W'(1);
              tl_timer_q  <= TIMER_W'(SCATTER_FRAMES);
              global_mode <= 1'b0;
            end
          end
          default: tl_state_q <= TL_CHASE_FINAL;
        endcase
      end else if (tl_run) begin
        tl_timer_q <= tl_timer_q - TIMER_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    ghost_life_fsm #(
      .START_ACTIVE (g == 0)
    ) u_life (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .game_en       (game_en),
      .caught        (ghost_caught[g]),
      .home          (ghost_home[g]),
      .fright_start  (power_eaten),
      .fright_end    (fright_end),
      .release_req   (rel_req[g]),
      .state         (g_state[g]),
      .release_pulse (release_pulse[g]),
      .catch_hit     (g_hit[g])
    );
    assign ghost_state[2*g +: 2] = g_state[g];
  end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ghost_mode_scheduler
// Directed bench for ghost_mode_scheduler with default parameters. Frames are
// numbered from 1 after each reset; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ghost_mode_scheduler;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       game_en;
  logic       pellet_eaten;
  logic       power_eaten;
  logic [3:0] ghost_caught;
  logic [3:0] ghost_home;
  logic       global_mode;
  logic [7:0] ghost_state;
  logic [3:0] release_pulse;
  logic       reverse;
  logic       flash;
  logic [1:0] score_mult;

  int test_cnt = 0;
  int fail_cnt = 0;
  int frame_no = 0;

  ghost_mode_scheduler dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .game_en       (game_en),
    .pellet_eaten  (pellet_eaten),
    .power_eaten   (power_eaten),
    .ghost_caught  (ghost_caught),
    .ghost_home    (ghost_home),
    .global_mode   (global_mode),
    .ghost_state   (ghost_state),
    .release_pulse (release_pulse),
    .reverse       (reverse),
    .flash         (flash),
    .score_mult    (score_mult)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s @frame %0d: observed %0h expected %0h", tag, frame_no, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic frame(input logic pe, input logic pw, input logic [3:0] c, input logic [3:0] h);
    pellet_eaten = pe;
    power_eaten  = pw;
    ghost_caught = c;
    ghost_home   = h;
    tick();
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
    ghost_caught = 4'h0;
    ghost_home   = 4'h0;
    frame_no++;
  endtask

  task automatic run_to(input int n);
    while (frame_no < n) frame(1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset    = 1'b0;
    frame_no = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; game_en = 1'b1; pellet_eaten = 1'b0; power_eaten = 1'b0;
    ghost_caught = 4'h0; ghost_home = 4'h0;
    @(negedge frame_clk);

    // ---- Reset values, scatter->chase timeline, idle-timer releases -------
    do_reset();
    check("rst_mode",  global_mode,   0);
    check("rst_state", ghost_state,   8'h01);
    check("rst_rel",   release_pulse, 4'h0);
    check("rst_rev",   reverse,       0);
    check("rst_flash", flash,         0);
    check("rst_score", score_mult,    0);
    run_to(1);   // ghost 1 needs zero pellets
    check("t1_rel_g1",   release_pulse, 4'b0010);
    check("t1_state_f1", ghost_state,   8'h05);
    run_to(239);
    check("t1_rel_239",  release_pulse, 4'h0);
    run_to(240); // 240 pellet-free frames force ghost 2 out
    check("t1_rel_g2",   release_pulse, 4'b0100);
    check("t1_state240", ghost_state,   8'h15);
    run_to(419);
    check("t1_mode419",  global_mode,   0);
    check("t1_rev419",   reverse,       0);
    run_to(420);
    check("t1_mode420",  global_mode,   1);
    check("t1_rev420",   reverse,       1);
    check("t1_state420", ghost_state,   8'h15);
    run_to(421);
    check("t1_rev421",   reverse,       0);
    check("t1_mode421",  global_mode,   1);
    run_to(480);
    check("t1_rel_g3",   release_pulse, 4'b1000);
    check("t1_state480", ghost_state,   8'h55);

    // ---- Pellet-count releases ---------------------------------------------
    do_reset();
    for (int p = 1; p <= 60; p++) begin
      frame(1'b1, 1'b0, 4'h0, 4'h0);
      if (p == 1)  check("t2_rel_p1",  release_pulse, 4'b0010);
      if (p == 29) check("t2_rel_p29", release_pulse, 4'b0000);
      if (p == 30) check("t2_rel_p30", release_pulse, 4'b0100);
      if (p == 59) begin
        check("t2_rel_p59",   release_pulse, 4'b0000);
        check("t2_state_p59", ghost_state,   8'h15);
      end
      if (p == 60) begin
        check("t2_rel_p60",   release_pulse, 4'b1000);
        check("t2_state_p60", ghost_state,   8'h55);
      end
    end

    // ---- Catching, same-cycle events, window reload, reset mid-window ------
    do_reset();
    for (int p = 1; p <= 60; p++) frame(1'b1, 1'b0, 4'h0, 4'h0);
    frame(1'b0, 1'b1, 4'h0, 4'h0);   // 61
    check("t4_pw_state", ghost_state, 8'hAA);
    check("t4_pw_rev",   reverse,     1);
    check("t4_pw_score", score_mult,  0);
    frame(1'b0, 1'b0, 4'b0001, 4'h0); // 62
    check("t4_c0_state", ghost_state, 8'hAB);
    check("t4_c0_score", score_mult,  1);
    frame(1'b0, 1'b0, 4'b0010, 4'h0); // 63
    check("t4_c1_state", ghost_state, 8'hAF);
    check("t4_c1_score", score_mult,  2);
    frame(1'b0, 1'b0, 4'b0100, 4'h0); // 64
    check("t4_c2_state", ghost_state, 8'hBF);
    check("t4_c2_score", score_mult,  3);
    frame(1'b0, 1'b0, 4'b1000, 4'h0); // 65
    check("t4_c3_state", ghost_state, 8'hFF);
    check("t4_c3_score", score_mult,  3);
    frame(1'b0, 1'b0, 4'h0, 4'b0001); // 66
    check("t4_home0",    ghost_state, 8'hFD);
    check("t4_home0_rev", reverse,    0);
    frame(1'b0, 1'b0, 4'b0001, 4'h0); // 67: catch of ACTIVE ghost ignored
    check("t4_ign_state", ghost_state, 8'hFD);
    check("t4_ign_score", score_mult,  3);
    frame(1'b0, 1'b0, 4'h0, 4'b0010); // 68: home mid-window -> ACTIVE
    check("t4_home1",    ghost_state, 8'hF5);
    frame(1'b0, 1'b1, 4'h0, 4'h0);    // 69
    check("t4_pw2_state", ghost_state, 8'hFA);
    check("t4_pw2_score", score_mult,  0);
    frame(1'b0, 1'b1, 4'b0010, 4'h0); // 70: power + catch together
    check("t4_same_state", ghost_state, 8'hFE);
    check("t4_same_score", score_mult,  1);
    check("t4_same_rev",   reverse,     1);
    run_to(309);
    check("t4_flash309", flash, 0);
    run_to(310);
    check("t4_flash310", flash, 1);
    game_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_frz_flash", flash, 1);
    end
    game_en = 1'b1;
    run_to(429);
    check("t4_flash429", flash,       1);
    check("t4_state429", ghost_state, 8'hFE);
    run_to(430);
    check("t4_exp_state", ghost_state, 8'hFD);
    check("t4_exp_flash", flash,       0);
    check("t4_exp_rev",   reverse,     0);
    frame(1'b0, 1'b0, 4'h0, 4'b1110); // 431
    check("t4_home_all", ghost_state, 8'h55);
    frame(1'b0, 1'b1, 4'h0, 4'h0);    // 432
    check("t4_pw3_state", ghost_state, 8'hAA);
    frame(1'b0, 1'b0, 4'b0011, 4'h0); // 433: two catches at once
    check("t4_dbl_state", ghost_state, 8'hAF);
    check("t4_dbl_score", score_mult,  2);
    frame(1'b0, 1'b0, 4'b1100, 4'h0); // 434: 2+2 saturates
    check("t4_sat_state", ghost_state, 8'hFF);
    check("t4_sat_score", score_mult,  3);
    // Reset beats a simultaneous power pellet and catch.
    Reset = 1'b1; power_eaten = 1'b1; ghost_caught = 4'hF;
    tick();
    Reset = 1'b0; power_eaten = 1'b0; ghost_caught = 4'h0; frame_no = 0;
    check("t5_state", ghost_state,   8'h01);
    check("t5_score", score_mult,    0);
    check("t5_flash", flash,         0);
    check("t5_rev",   reverse,       0);
    check("t5_mode",  global_mode,   0);
    check("t5_rel",   release_pulse, 4'h0);
    run_to(1);
    check("t5_rel_f1", release_pulse, 4'b0010);
    check("t5_flash1", flash,         0);

    // ---- Frightened window timing and timeline pause -----------------------
    do_reset();
    run_to(99);
    frame(1'b0, 1'b1, 4'h0, 4'h0);    // 100
    check("t3_state100", ghost_state, 8'h0A);
    check("t3_rev100",   reverse,     1);
    check("t3_flash100", flash,       0);
    run_to(101);
    check("t3_rev101",   reverse,     0);
    run_to(339);
    check("t3_flash339", flash,       0);
    run_to(340);
    check("t3_flash340", flash,         1);
    check("t3_rel340",   release_pulse, 4'b0100);
    check("t3_state340", ghost_state,   8'h1A);
    run_to(459);
    check("t3_flash459", flash,       1);
    check("t3_state459", ghost_state, 8'h1A);
    run_to(460);
    check("t3_state460", ghost_state, 8'h15);
    check("t3_flash460", flash,       0);
    check("t3_rev460",   reverse,     0);
    run_to(580);
    check("t3_rel580",   release_pulse, 4'b1000);
    run_to(779);
    check("t3_mode779",  global_mode, 0);
    run_to(780);
    check("t3_mode780",  global_mode, 1);
    check("t3_rev780",   reverse,     1);

    // ---- Freeze: inputs ignored, counters hold -----------------------------
    do_reset();
    run_to(200);
    check("t6_state200", ghost_state, 8'h05);
    game_en = 1'b0; pellet_eaten = 1'b1; power_eaten = 1'b1; ghost_caught = 4'hF;
    for (int k = 0; k < 50; k++) begin
      tick();
      check("t6_frz_rev",   reverse,     0);
      check("t6_frz_state", ghost_state, 8'h05);
      check("t6_frz_rel",   release_pulse, 4'h0);
    end
    game_en = 1'b1; pellet_eaten = 1'b0; power_eaten = 1'b0; ghost_caught = 4'h0;
    run_to(239);
    check("t6_rel239",   release_pulse, 4'h0);
    check("t6_score239", score_mult,    0);
    run_to(240);
    check("t6_rel240",   release_pulse, 4'b0100);
    run_to(419);
    check("t6_mode419",  global_mode, 0);
    run_to(420);
    check("t6_mode420",  global_mode, 1);
    check("t6_rev420",   reverse,     1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
